multicycle_ctrl: RTL and testbench

//  Multicycle control FSM for the 16-bit, 16-opcode ISA. It sequences each instruction through

---
 rtl/multicycle_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the 16-opcode ISA; optional retire counter under MULTICYCLE_CTRL_PERF_CNT_EN.
// Latency 2-5 cycles/instr at zero wait; mem_rdy=0 stalls FETCH/MEM, watchdog halts a stuck access.
module multicycle_ctrl #(
  parameter int ALU_OP_W     = 4,
  parameter int MEM_WAIT_MAX = 15,
  parameter int WD_W         = 4,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          opcode,
  input  logic                cond_met,
  input  logic                mem_rdy,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic                iord,
  output logic                ir_we,
  output logic                pc_we,
  output logic [1:0]          pc_src,
  output logic [1:0]          reg_dst,
  output logic [1:0]          mem_to_reg,
  output logic                alu_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                reg_write,
  output logic                halted,
  output logic                mem_err
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]    instr_count
`endif
);

  typedef enum logic [2:0] {
    sInit, sFetch, sDecode, sExec, sMem, sWb, sHalt
  } stateT;

  localparam logic [3:0] opLw  = 4'h8;
  localparam logic [3:0] opSw  = 4'h9;
  localparam logic [3:0] opLlb = 4'hA;
  localparam logic [3:0] opLhb = 4'hB;
  localparam logic [3:0] opB   = 4'hC;
  localparam logic [3:0] opJal = 4'hD;
  localparam logic [3:0] opJr  = 4'hE;
  localparam logic [3:0] opHlt = 4'hF;

  if (ALU_OP_W < 4) begin : gBadAluOpW
    $error("multicycle_ctrl: ALU_OP_W must be >= 4");
  end
  if (MEM_WAIT_MAX < 0 || MEM_WAIT_MAX >= (1 << WD_W)) begin : gBadWdW
    $error("multicycle_ctrl: WD_W too narrow for MEM_WAIT_MAX");
  end
  if (CNT_W < 1) begin : gBadCntW
    $error("multicycle_ctrl: CNT_W must be >= 1");
  end

  stateT           state;
  logic [WD_W-1:0] wdCnt;
  logic            memErr;
  logic            memWait;
  logic            wdTrip;
  logic            isLdSt;
  logic            retire;

  assign isLdSt  = (opcode == opLw) || (opcode == opSw);
  assign memWait = ((state == sFetch) || (state == sMem)) && !mem_rdy;
  // The timeout cycle itself still requests; outputs fall once HALT is entered.
  assign wdTrip  = (MEM_WAIT_MAX > 0) && memWait && (wdCnt == WD_W'(MEM_WAIT_MAX));

  assign retire = ((state == sDecode) &&
                   ((opcode == opB) || (opcode == opJr) || (opcode == opJal))) ||
                  ((state == sMem) && (opcode == opSw) && mem_rdy) ||
                  (state == sWb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= sInit;
      wdCnt  <= '0;
      memErr <= 1'b0;
    end else begin
      if (!memWait) begin
        wdCnt <= '0;
      end else if (wdCnt != {WD_W{1'b1}}) begin
        wdCnt <= wdCnt + 1'b1;
      end

      if (wdTrip) begin
        memErr <= 1'b1;
        state  <= sHalt;
      end else begin
        case (state)
          sInit:   state <= sFetch;
          sFetch:  if (mem_rdy) state <= sDecode;
          sDecode: begin
            case (opcode)
              opHlt:           state <= sHalt;
              opB, opJr, opJal: state <= sFetch;
              default:         state <= sExec;
            endcase
          end
          sExec:   state <= isLdSt ? sMem : sWb;
          sMem: begin
            if (mem_rdy) state <= (opcode == opLw) ? sWb : sFetch;
          end
          sWb:     state <= sFetch;
          sHalt:   state <= sHalt;
          default: state <= sInit;
        endcase
      end
    end
  end

  always_comb begin
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'd0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    alu_src    = 1'b0;
    alu_op     = '0;
    reg_write  = 1'b0;
    halted     = 1'b0;
    case (state)
      sFetch: begin
        mem_rd = 1'b1;
        if (mem_rdy) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
        end
      end
      sDecode: begin
        case (opcode)
          opB: begin
            pc_we  = cond_met;
            pc_src = 2'd1;
          end
          opJr: begin
            pc_we  = 1'b1;
            pc_src = 2'd3;
          end
          opJal: begin
            reg_write  = 1'b1;
            reg_dst    = 2'd2;
            mem_to_reg = 2'd2;
            pc_we      = 1'b1;
            pc_src     = 2'd2;
          end
          default: ;
        endcase
      end
      sExec: begin
        if (isLdSt) begin
          alu_src = 1'b1;
        end else begin
          alu_op  = ALU_OP_W'(opcode);
          alu_src = (opcode == opLlb) || (opcode == opLhb);
        end
      end
      sMem: begin
        iord   = 1'b1;
        mem_rd = (opcode == opLw);
        mem_wr = (opcode == opSw);
      end
      sWb: begin
        reg_write = 1'b1;
        if (opcode == opLw) begin
          mem_to_reg = 2'd1;
        end else if ((opcode != opLlb) && (opcode != opLhb)) begin
          reg_dst = 2'd1;
        end
      end
      sHalt:   halted = 1'b1;
      default: ;
    endcase
  end

  assign mem_err = memErr;

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] instrCount;

  // HALT never retires, so the count freezes there without an extra guard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instrCount <= '0;
    end else if (retire) begin
      instrCount <= instrCount + 1'b1;
    end
  end

  assign instr_count = instrCount;
`else
  logic unusedRetire;
  assign unusedRetire = retire;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle output vectors checked against hand-computed values.
module tb_multicycle_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] opcode;
  logic       cond_met;
  logic       mem_rdy;
  logic       mem_rd, mem_wr, iord, ir_we, pc_we, alu_src, reg_write, halted, mem_err;
  logic [1:0] pc_src, reg_dst, mem_to_reg;
  logic [3:0] alu_op;
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  logic [15:0] instr_count;
`endif

  int tests = 0;
  int fails = 0;

  multicycle_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .cond_met   (cond_met),
    .mem_rdy    (mem_rdy),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .iord       (iord),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .halted     (halted),
    .mem_err    (mem_err)
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    ,
    .instr_count(instr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [18:0] obs;
  assign obs = {mem_rd, mem_wr, iord, ir_we, pc_we, pc_src, reg_dst, mem_to_reg,
                alu_src, alu_op, reg_write, halted, mem_err};

  function automatic logic [18:0] ev(input int mrd, mwr, io, irw, pcw, ps, rd, m2r,
                                     input int as, ao, rw, h, me);
    return {1'(mrd), 1'(mwr), 1'(io), 1'(irw), 1'(pcw), 2'(ps), 2'(rd), 2'(m2r),
            1'(as), 4'(ao), 1'(rw), 1'(h), 1'(me)};
  endfunction

  task automatic chk(input string tag, input logic [18:0] e);
    tests++;
    assert (obs === e) else begin
      fails++;
      $error("FAIL %s: outputs %h, expected %h", tag, obs, e);
    end
  endtask

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  task automatic chkCnt(input string tag, input logic [15:0] e);
    tests++;
    assert (instr_count === e) else begin
      fails++;
      $error("FAIL %s: instr_count %0d, expected %0d", tag, instr_count, e);
    end
  endtask
`endif

  // Called on a falling edge: drive inputs, check this cycle, advance one clock.
  task automatic step(input logic [3:0] op, input logic rdy, input logic cm,
                      input string tag, input logic [18:0] e);
    opcode   = op;
    mem_rdy  = rdy;
    cond_met = cm;
    #1 chk(tag, e);
    @(negedge clk);
  endtask

  logic [18:0] eIdle, eFetch, eFetchWait, eHalt;

  initial begin
    eIdle      = ev(0,0,0,0,0,0,0,0,0,0,0,0,0);
    eFetch     = ev(1,0,0,1,1,0,0,0,0,0,0,0,0);
    eFetchWait = ev(1,0,0,0,0,0,0,0,0,0,0,0,0);
    eHalt      = ev(0,0,0,0,0,0,0,0,0,0,0,1,0);

    rst_n = 1'b0; opcode = 4'h0; cond_met = 1'b0; mem_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 chk("reset outputs", eIdle);
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    chkCnt("reset count", 16'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // ADD
    step(4'h0, 1'b1, 1'b0, "add init",   eIdle);
    step(4'h0, 1'b1, 1'b0, "add fetch",  eFetch);
    step(4'h0, 1'b1, 1'b0, "add decode", eIdle);
    step(4'h0, 1'b1, 1'b0, "add exec",   eIdle);
    step(4'h0, 1'b1, 1'b0, "add wb",     ev(0,0,0,0,0,0,1,0,0,0,1,0,0));
    // fetch stalls twice, then opcode 5
    step(4'h5, 1'b0, 1'b0, "fetch wait1", eFetchWait);
    step(4'h5, 1'b0, 1'b0, "fetch wait2", eFetchWait);
    step(4'h5, 1'b1, 1'b0, "op5 fetch",   eFetch);
    step(4'h5, 1'b1, 1'b0, "op5 decode",  eIdle);
    step(4'h5, 1'b1, 1'b0, "op5 exec",    ev(0,0,0,0,0,0,0,0,0,5,0,0,0));
    step(4'h5, 1'b1, 1'b0, "op5 wb",      ev(0,0,0,0,0,0,1,0,0,0,1,0,0));
    // LLB
    step(4'hA, 1'b1, 1'b0, "llb fetch",   eFetch);
    step(4'hA, 1'b1, 1'b0, "llb decode",  eIdle);
    step(4'hA, 1'b1, 1'b0, "llb exec",    ev(0,0,0,0,0,0,0,0,1,10,0,0,0));
    step(4'hA, 1'b1, 1'b0, "llb wb",      ev(0,0,0,0,0,0,0,0,0,0,1,0,0));
    // LW with three memory wait cycles
    step(4'h8, 1'b1, 1'b0, "lw fetch",    eFetch);
    step(4'h8, 1'b1, 1'b0, "lw decode",   eIdle);
    step(4'h8, 1'b1, 1'b0, "lw exec",     ev(0,0,0,0,0,0,0,0,1,0,0,0,0));
    for (int i = 0; i < 3; i++)
      step(4'h8, 1'b0, 1'b0, "lw mem wait", ev(1,0,1,0,0,0,0,0,0,0,0,0,0));
    step(4'h8, 1'b1, 1'b0, "lw mem done", ev(1,0,1,0,0,0,0,0,0,0,0,0,0));
    step(4'h8, 1'b1, 1'b0, "lw wb",       ev(0,0,0,0,0,0,0,1,0,0,1,0,0));
    // SW
    step(4'h9, 1'b1, 1'b0, "sw fetch",    eFetch);
    step(4'h9, 1'b1, 1'b0, "sw decode",   eIdle);
    step(4'h9, 1'b1, 1'b0, "sw exec",     ev(0,0,0,0,0,0,0,0,1,0,0,0,0));
    step(4'h9, 1'b1, 1'b0, "sw mem",      ev(0,1,1,0,0,0,0,0,0,0,0,0,0));
    // B not taken, then taken
    step(4'hC, 1'b1, 1'b0, "b0 fetch",    eFetch);
    step(4'hC, 1'b1, 1'b0, "b0 decode",   ev(0,0,0,0,0,1,0,0,0,0,0,0,0));
    step(4'hC, 1'b1, 1'b1, "b1 fetch",    eFetch);
    step(4'hC, 1'b1, 1'b1, "b1 decode",   ev(0,0,0,0,1,1,0,0,0,0,0,0,0));
    // JR, JAL
    step(4'hE, 1'b1, 1'b0, "jr fetch",    eFetch);
    step(4'hE, 1'b1, 1'b0, "jr decode",   ev(0,0,0,0,1,3,0,0,0,0,0,0,0));
    step(4'hD, 1'b1, 1'b0, "jal fetch",   eFetch);
    step(4'hD, 1'b1, 1'b0, "jal decode",  ev(0,0,0,0,1,2,2,2,0,0,1,0,0));
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    opcode = 4'h9;
    #1 chkCnt("nine retired", 16'd9);
`endif
    // SW stalled in MEM, reset pulled mid-cycle
    step(4'h9, 1'b1, 1'b0, "sw2 fetch",   eFetch);
    step(4'h9, 1'b1, 1'b0, "sw2 decode",  eIdle);
    step(4'h9, 1'b1, 1'b0, "sw2 exec",    ev(0,0,0,0,0,0,0,0,1,0,0,0,0));
    opcode = 4'h9; mem_rdy = 1'b0;
    #1 chk("sw2 mem held", ev(0,1,1,0,0,0,0,0,0,0,0,0,0));
    #2 rst_n = 1'b0;
    #1 chk("async reset", eIdle);
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    chkCnt("count after reset", 16'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step(4'hF, 1'b1, 1'b0, "restart init",  eIdle);
    step(4'hF, 1'b1, 1'b0, "restart fetch", eFetch);
    // HLT
    step(4'hF, 1'b1, 1'b0, "hlt decode",  eIdle);
    step(4'hF, 1'b1, 1'b0, "halt 1",      eHalt);
    step(4'h0, 1'b0, 1'b1, "halt 2",      eHalt);
    step(4'h8, 1'b1, 1'b0, "halt 3",      eHalt);
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    #1 chkCnt("count frozen", 16'd0);
`endif
    // Watchdog: memory never answers in FETCH
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(4'h0, 1'b0, 1'b0, "wd init", eIdle);
    for (int i = 0; i < 16; i++)
      step(4'h0, 1'b0, 1'b0, "wd waiting", eFetchWait);
    step(4'h0, 1'b0, 1'b0, "wd timeout",  ev(0,0,0,0,0,0,0,0,0,0,0,1,1));
    step(4'h0, 1'b1, 1'b0, "wd sticky",   ev(0,0,0,0,0,0,0,0,0,0,0,1,1));
    rst_n = 1'b0;
    #1 chk("err cleared", eIdle);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
